// File: rtl/flit_assembler_16_to_32_bit_if.sv
// Halfword-in / word-out flit streams between a producer, the assembler and a sink.
// The slave modport is the assembler's view; master is the producer/sink side.
interface flit_assembler_16_to_32_bit_if;
   logic [15:0] in_flit_data;
   logic        in_flit_valid;
   logic        in_flit_last;
   logic        in_flit_ready;
   logic [31:0] out_flit_data;
   logic        out_flit_valid;
   logic        out_flit_last;
   logic        out_flit_16;
   logic        out_flit_ready;

   modport slave (
      input  in_flit_data, in_flit_valid, in_flit_last, out_flit_ready,
      output in_flit_ready, out_flit_data, out_flit_valid, out_flit_last, out_flit_16
   );

   modport master (
      output in_flit_data, in_flit_valid, in_flit_last, out_flit_ready,
      input  in_flit_ready, out_flit_data, out_flit_valid, out_flit_last, out_flit_16
   );
endinterface

// File: rtl/flit_assembler_16_to_32_bit.sv
// Packs pairs of 16-bit halfwords into 32-bit flits (first halfword in the low half)
// and buffers the flits in a small FIFO so a stalled sink only back-pressures the input.
module flit_assembler_16_to_32_bit #(
   parameter int MAX_PKT_LEN = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   flit_assembler_16_to_32_bit_if.slave   bus
);
   localparam int DEPTH = 1 << $clog2(MAX_PKT_LEN + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {LOWER, UPPER} state_t;

   typedef struct packed {
      logic        f16;
      logic        last;
      logic [31:0] data;
   } entry_t;

   state_t             state_q, state_d;
   logic [15:0]        hold_q, hold_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   entry_t             mem_q [DEPTH];

   logic   fifo_full, fifo_empty;
   logic   in_xfer, push, pop;
   entry_t push_entry, head;

   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign in_xfer    = bus.in_flit_valid && !fifo_full;
   assign pop        = !fifo_empty && bus.out_flit_ready;

   // Pairing FSM: a lone last halfword in LOWER becomes a zero-extended 16-bit flit.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      push       = 1'b0;
      push_entry = '0;
      unique case (state_q)
         LOWER: begin
            if (in_xfer) begin
               if (bus.in_flit_last) begin
                  push       = 1'b1;
                  push_entry = '{f16: 1'b1, last: 1'b1, data: {16'h0000, bus.in_flit_data}};
               end else begin
                  hold_d  = bus.in_flit_data;
                  state_d = UPPER;
               end
            end
         end
         UPPER: begin
            if (in_xfer) begin
               push       = 1'b1;
               push_entry = '{f16: 1'b0, last: bus.in_flit_last, data: {bus.in_flit_data, hold_q}};
               state_d    = LOWER;
            end
         end
         default: state_d = LOWER;
      endcase
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOWER;
         hold_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; occupancy gates every read, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign head               = mem_q[rd_ptr_q];
   assign bus.in_flit_ready  = !fifo_full;
   assign bus.out_flit_valid = !fifo_empty;
   assign bus.out_flit_data  = fifo_empty ? 32'h0 : head.data;
   assign bus.out_flit_last  = fifo_empty ? 1'b0  : head.last;
   assign bus.out_flit_16    = fifo_empty ? 1'b0  : head.f16;
endmodule

// File: tb/tb_flit_assembler_16_to_32_bit.sv
// Directed and randomized checks of the 16-to-32-bit flit assembler against a
// packet-level packing model (ceil(N/2) flits per N-halfword packet).
module tb_flit_assembler_16_to_32_bit;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   flit_assembler_16_to_32_bit_if bus ();

   flit_assembler_16_to_32_bit #(.MAX_PKT_LEN(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   // Stream queues: source entries are {last, halfword}; observed flits are {f16, last, data}.
   logic [16:0] src_q[$];
   logic [33:0] got_q[$];
   logic [33:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] out_word();
      return {bus.out_flit_16, bus.out_flit_last, bus.out_flit_data};
   endfunction

   // Packing rule at packet level: pair halfwords low-first, odd tail becomes a 16-bit flit.
   task automatic model_packet(input logic [15:0] hw[$]);
      int n = hw.size();
      for (int i = 0; i < n; i += 2) begin
         if (i + 1 < n) exp_q.push_back({1'b0, (i + 2 == n), hw[i+1], hw[i]});
         else           exp_q.push_back({1'b1, 1'b1, 16'h0000, hw[i]});
      end
   endtask

   task automatic queue_packet(input logic [15:0] hw[$]);
      for (int i = 0; i < hw.size(); i++) src_q.push_back({(i == hw.size() - 1), hw[i]});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_flit_valid  = 1'b0;
      bus.out_flit_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives src_q with random valid, random ready; collects flits until n_exp arrive or budget expires.
   task automatic run_stream(input int vp, input int rp, input int n_exp, input int budget);
      int          cyc = 0;
      logic        held = 1'b0;
      logic [33:0] held_word = '0;
      logic        in_x, out_x;
      while ((src_q.size() > 0 || got_q.size() < n_exp) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (src_q.size() > 0 && $urandom_range(99) < vp) begin
            bus.in_flit_valid = 1'b1;
            bus.in_flit_data  = src_q[0][15:0];
            bus.in_flit_last  = src_q[0][16];
         end else begin
            bus.in_flit_valid = 1'b0;
            bus.in_flit_data  = 16'($urandom);
            bus.in_flit_last  = 1'($urandom);
         end
         bus.out_flit_ready = ($urandom_range(99) < rp);
         #1;
         if (held) check("stall_stable", out_word(), held_word);
         in_x  = bus.in_flit_valid && bus.in_flit_ready;
         out_x = bus.out_flit_valid && bus.out_flit_ready;
         held      = bus.out_flit_valid && !bus.out_flit_ready;
         held_word = out_word();
         if (out_x) got_q.push_back(out_word());
         @(posedge clk);
         if (in_x) void'(src_q.pop_front());
      end
      @(negedge clk);
      bus.in_flit_valid  = 1'b0;
      bus.out_flit_ready = 1'b0;
      check("stream_budget", 64'(cyc < budget), 64'(1));
   endtask

   task automatic compare_streams(input string tag);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [15:0] pkt[$];
      int          accepted;

      bus.in_flit_data   = '0;
      bus.in_flit_valid  = 1'b0;
      bus.in_flit_last   = 1'b0;
      bus.out_flit_ready = 1'b0;

      // Reset state
      do_reset();
      #1;
      check("rst_out_valid", 64'(bus.out_flit_valid), 64'(0));
      check("rst_in_ready", 64'(bus.in_flit_ready), 64'(1));
      check("rst_out_word", 64'(out_word()), 64'(0));

      // Even-length packet
      pkt = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      queue_packet(pkt);
      exp_q.push_back({1'b0, 1'b0, 32'h22221111});
      exp_q.push_back({1'b0, 1'b1, 32'h44443333});
      run_stream(100, 100, 2, 50);
      compare_streams("even_pkt");

      // Odd-length packet: tail zero-extended and flagged 16-bit
      pkt = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      queue_packet(pkt);
      exp_q.push_back({1'b0, 1'b0, 32'hBBBBAAAA});
      exp_q.push_back({1'b1, 1'b1, 32'h0000CCCC});
      run_stream(100, 100, 2, 50);
      compare_streams("odd_pkt");

      // Single-halfword packet latency: nothing combinational, visible one edge later
      @(negedge clk);
      bus.in_flit_valid = 1'b1;
      bus.in_flit_data  = 16'h5A5A;
      bus.in_flit_last  = 1'b1;
      #1;
      check("single_no_comb", 64'(bus.out_flit_valid), 64'(0));
      @(posedge clk);
      #1;
      bus.in_flit_valid = 1'b0;
      check("single_valid", 64'(bus.out_flit_valid), 64'(1));
      check("single_word", 64'(out_word()), 64'({1'b1, 1'b1, 32'h00005A5A}));
      @(negedge clk);
      bus.out_flit_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_flit_ready = 1'b0;
      check("single_drained", 64'(bus.out_flit_valid), 64'(0));

      // Back-pressure: 40 halfwords into a stalled sink, only 32 fit (16 entries)
      do_reset();
      pkt.delete();
      for (int i = 0; i < 40; i++) pkt.push_back(16'h0100 + 16'(i));
      accepted = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         bus.in_flit_valid = (accepted < 40);
         bus.in_flit_data  = pkt[accepted % 40];
         bus.in_flit_last  = (accepted == 39);
         #1;
         if (bus.in_flit_valid && bus.in_flit_ready) accepted++;
         @(posedge clk);
      end
      @(negedge clk);
      bus.in_flit_valid = 1'b0;
      #1;
      check("full_accepted", 64'(accepted), 64'(32));
      check("full_in_ready", 64'(bus.in_flit_ready), 64'(0));
      check("full_head", 64'(out_word()), 64'({1'b0, 1'b0, 32'h01010100}));
      model_packet(pkt);
      @(negedge clk);
      bus.out_flit_ready = 1'b1;
      #1;
      got_q.push_back(out_word());
      @(posedge clk);
      #1;
      check("ready_after_pop", 64'(bus.in_flit_ready), 64'(1));
      for (int i = 32; i < 40; i++) src_q.push_back({(i == 39), pkt[i]});
      run_stream(100, 100, 20, 200);
      compare_streams("full_drain");

      // Reset mid-packet discards the held halfword
      @(negedge clk);
      bus.in_flit_valid = 1'b1;
      bus.in_flit_data  = 16'h1234;
      bus.in_flit_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_flit_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_empty", 64'(bus.out_flit_valid), 64'(0));
      src_q.push_back({1'b1, 16'h9999});
      exp_q.push_back({1'b1, 1'b1, 32'h00009999});
      run_stream(100, 100, 1, 50);
      repeat (4) @(posedge clk);
      #1;
      check("midrst_no_extra", 64'(bus.out_flit_valid), 64'(0));
      compare_streams("midrst");

      // Randomized packets with random valid/ready against the packing model
      for (int p = 0; p < 1000; p++) begin
         int len = $urandom_range(20, 1);
         pkt.delete();
         for (int i = 0; i < len; i++) pkt.push_back(16'($urandom));
         queue_packet(pkt);
         model_packet(pkt);
      end
      run_stream(80, 70, exp_q.size(), 60000);
      compare_streams("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
